// File: rtl/gate_dec_pkg.sv
// -----------------------------------------------------------------------------
// gate_dec_pkg
// Shared definitions for the gate-vector decoder.
//   - Bit positions of each gate result inside the 7-bit vector
//     {xnor,xor,nor,nand,not,or,and} = [6:0]
//   - The four legal codewords CW_00..CW_11, indexed by operands (a,b)
//   - FSM state enum
//   - Hamming-distance helper, present only when GATE_DEC_CORRECT_EN is
//     defined (single-bit correction build)
// -----------------------------------------------------------------------------
package gate_dec_pkg;

   // Position of each gate result within the vector
   localparam int BIT_AND  = 0;
   localparam int BIT_OR   = 1;
   localparam int BIT_NOT  = 2;
   localparam int BIT_NAND = 3;
   localparam int BIT_NOR  = 4;
   localparam int BIT_XOR  = 5;
   localparam int BIT_XNOR = 6;

   typedef enum logic {ST_RUN, ST_LOCK} state_t;

   // Builds the vector the gate bank produces for operands (a,b). The NOT
   // lane carries ~a.
   function automatic logic [6:0] gate_vec(input logic a, input logic b);
      logic [6:0] v;
      v           = '0;
      v[BIT_AND]  = a & b;
      v[BIT_OR]   = a | b;
      v[BIT_NOT]  = ~a;
      v[BIT_NAND] = ~(a & b);
      v[BIT_NOR]  = ~(a | b);
      v[BIT_XOR]  = a ^ b;
      v[BIT_XNOR] = ~(a ^ b);
      return v;
   endfunction

   // Legal codewords: 00 -> 1011100, 01 -> 0101110, 10 -> 0101010, 11 -> 1000011
   localparam logic [6:0] CW_00 = gate_vec(1'b0, 1'b0);
   localparam logic [6:0] CW_01 = gate_vec(1'b0, 1'b1);
   localparam logic [6:0] CW_10 = gate_vec(1'b1, 1'b0);
   localparam logic [6:0] CW_11 = gate_vec(1'b1, 1'b1);

`ifdef GATE_DEC_CORRECT_EN
   // Number of differing bit positions between two vectors
   function automatic logic [2:0] bit_dist(input logic [6:0] x, input logic [6:0] y);
      logic [6:0] d;
      logic [2:0] n;
      d = x ^ y;
      n = '0;
      for (int i = 0; i < 7; i++) begin
         n = n + {2'b00, d[i]};
      end
      return n;
   endfunction
`endif

endpackage

// File: rtl/gate_cw_match.sv
// -----------------------------------------------------------------------------
// gate_cw_match
// Combinational codeword matcher. Maps a 7-bit gate vector back to (a,b).
// Optional macro: GATE_DEC_CORRECT_EN enables single-bit correction.
// Ports:
//   in_vec  in   7  gate vector {xnor,xor,nor,nand,not,or,and}
//   hit     out  1  vector decoded to a legal (a,b) (exact or corrected)
//   a       out  1  recovered operand a (0 when hit=0)
//   b       out  1  recovered operand b (0 when hit=0)
//   corr    out  1  result came from single-bit correction
// -----------------------------------------------------------------------------
module gate_cw_match
   import gate_dec_pkg::*;
(
   input  logic [6:0] in_vec,
   output logic       hit,
   output logic       a,
   output logic       b,
   output logic       corr
);

`ifdef GATE_DEC_CORRECT_EN
   // One flag per codeword: is the incoming vector exactly one bit away?
   logic [3:0] near;
   assign near[0] = (bit_dist(in_vec, CW_00) == 3'd1);
   assign near[1] = (bit_dist(in_vec, CW_01) == 3'd1);
   assign near[2] = (bit_dist(in_vec, CW_10) == 3'd1);
   assign near[3] = (bit_dist(in_vec, CW_11) == 3'd1);
`endif

   // Exact match first; on a miss, correction is attempted only when exactly
   // one codeword is at distance 1 (CW_01 and CW_10 are themselves only one
   // bit apart, so ambiguous vectors must stay illegal).
   always_comb begin
      hit  = 1'b0;
      a    = 1'b0;
      b    = 1'b0;
      corr = 1'b0;
      case (in_vec)
         CW_00: begin hit = 1'b1; end
         CW_01: begin hit = 1'b1; b = 1'b1; end
         CW_10: begin hit = 1'b1; a = 1'b1; end
         CW_11: begin hit = 1'b1; a = 1'b1; b = 1'b1; end
         default: begin
`ifdef GATE_DEC_CORRECT_EN
            case (near)
               4'b0001: begin hit = 1'b1; corr = 1'b1; end
               4'b0010: begin hit = 1'b1; corr = 1'b1; b = 1'b1; end
               4'b0100: begin hit = 1'b1; corr = 1'b1; a = 1'b1; end
               4'b1000: begin hit = 1'b1; corr = 1'b1; a = 1'b1; b = 1'b1; end
               default: begin hit = 1'b0; end
            endcase
`else
            hit = 1'b0;
`endif
         end
      endcase
   end

endmodule

// File: rtl/gate_vector_decoder.sv
// -----------------------------------------------------------------------------
// gate_vector_decoder
// Recovers operands (a,b) from gate-bank vectors, flags illegal vectors,
// counts words/errors and locks the input after ERR_LIMIT consecutive errors.
// One registered output stage with valid/ready on both sides.
// Optional macro: GATE_DEC_CORRECT_EN (single-bit correction; out_corr is 0
// when it is not defined).
// Parameters:
//   CNT_W      width of saturating word/error counters
//   ERR_LIMIT  consecutive illegal words that force LOCK (1..15)
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake, in_vec gate vector
//   clear                 sync pulse: leave LOCK, zero counters
//   out_valid/out_ready   downstream handshake
//   out_a, out_b          recovered operands
//   out_err, out_corr     illegal / corrected flags
//   word_count, err_count saturating counters
//   locked                FSM is in LOCK
// -----------------------------------------------------------------------------
module gate_vector_decoder
   import gate_dec_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int ERR_LIMIT = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_vec,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_a,
   output logic             out_b,
   output logic             out_err,
   output logic             out_corr,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] err_count,
   output logic             locked
);

   localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);

   state_t     state;
   logic [3:0] consec_err;
   logic       m_hit;
   logic       m_a;
   logic       m_b;
   logic       m_corr;
   logic       accept;

   gate_cw_match u_match (
      .in_vec (in_vec),
      .hit    (m_hit),
      .a      (m_a),
      .b      (m_b),
      .corr   (m_corr)
   );

   // The output register may take a new word when it is empty or being
   // drained this cycle; LOCK shuts the input regardless.
   assign locked   = (state == ST_LOCK);
   assign in_ready = (~out_valid | out_ready) & ~locked;
   assign accept   = in_valid & in_ready;

   // Output pipeline register. Data is only loaded on acceptance so it stays
   // stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_a     <= 1'b0;
         out_b     <= 1'b0;
         out_err   <= 1'b0;
         out_corr  <= 1'b0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_a     <= m_a;
            out_b     <= m_b;
            out_err   <= ~m_hit;
            out_corr  <= m_corr;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // RUN/LOCK FSM with the consecutive-error tracker and the two saturating
   // counters. clear overrides any acceptance in the same cycle for counter
   // purposes; the word itself still reaches the output register above.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         consec_err <= '0;
         word_count <= '0;
         err_count  <= '0;
      end else if (clear) begin
         state      <= ST_RUN;
         consec_err <= '0;
         word_count <= '0;
         err_count  <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (accept) begin
                  if (word_count != '1) begin
                     word_count <= word_count + 1'b1;
                  end
                  if (!m_hit) begin
                     if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                     end
                     consec_err <= consec_err + 4'd1;
                     if (consec_err + 4'd1 == LIMIT) begin
                        state <= ST_LOCK;
                     end
                  end else begin
                     consec_err <= '0;
                  end
               end
            end
            ST_LOCK: begin
               state <= ST_LOCK;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule
